// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with registered outputs
module seq_detect_param #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
    parameter int              CNT_W   = 8,
    localparam int             PG_W    = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [PG_W-1:0]  progress,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              hit;
    logic              accept;
    logic [PG_W-1:0]   prog_n;

    assign accept = din_valid && !pat_load;

    // Progress is the longest proper prefix of the pattern that ends the new history.
    always_comb begin
        hist_n = {hist[PAT_W-2:0], din};
        fill_n = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
        hit    = (fill_n == FILL_W'(PAT_W)) && (hist_n == pattern);
        prog_n = '0;
        for (int k = 1; k < PAT_W; k++) begin
            if ((FILL_W'(k) <= fill_n) &&
                ((hist_n & ({PAT_W{1'b1}} >> (PAT_W - k))) == (pattern >> (PAT_W - k)))) begin
                prog_n = PG_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= '0;
            fill     <= '0;
            match    <= 1'b0;
            progress <= '0;
            pattern  <= PAT_RST;
        end else if (pat_load) begin
            pattern  <= pat_in;
            hist     <= '0;
            fill     <= '0;
            match    <= 1'b0;
            progress <= '0;
        end else if (din_valid) begin
            match <= hit;
            if (hit && !overlap) begin
                hist     <= '0;
                fill     <= '0;
                progress <= '0;
            end else begin
                hist     <= hist_n;
                fill     <= fill_n;
                progress <= prog_n;
            end
        end else begin
            match <= 1'b0;
        end
    end

    // Clear wins over a coincident hit; the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (accept && hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_valid, din, overlap, pat_load, cnt_clr;
    logic [3:0] pat_in;
    logic       match, match2;
    logic [1:0] progress, progress2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [3:0] pattern, pattern2;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .match(match),
        .progress(progress), .match_cnt(match_cnt), .pattern(pattern)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr), .match(match2),
        .progress(progress2), .match_cnt(match_cnt2), .pattern(pattern2)
    );

    typedef struct {
        logic       v;
        logic       d;
        logic       m;
        logic [1:0] p;
        logic [7:0] c;
        logic       l;
        logic       k;
    } stim_t;

    stim_t sb[$];
    stim_t e;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic stim_t mk(int v, int d, int m, int p, int c, int l = 0, int k = 0);
        stim_t s;
        s.v = v[0]; s.d = d[0]; s.m = m[0]; s.p = p[1:0]; s.c = c[7:0]; s.l = l[0]; s.k = k[0];
        return s;
    endfunction

    task automatic apply_reset();
        din_valid = 0; din = 0; pat_load = 0; cnt_clr = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; din_valid = 0; din = 0; overlap = 1; pat_load = 0; pat_in = 0; cnt_clr = 0;
        @(posedge clk); #1;
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset match: got %0b expected 0", match); end
        n_checks++; if (progress !== 2'd0) begin n_fail++; $display("FAIL reset progress: got %0d expected 0", progress); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset match_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (pattern !== 4'b1101) begin n_fail++; $display("FAIL reset pattern: got %b expected 1101", pattern); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        stim_t t[$];
        apply_reset(); overlap = 1;
        t.push_back(mk(1,1,0,1,0)); t.push_back(mk(1,1,0,2,0));
        t.push_back(mk(1,0,0,3,0)); t.push_back(mk(1,1,1,1,1));
        t.push_back(mk(0,0,0,1,1));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL basic match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL basic progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL basic match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    task automatic test_repeat_prefix();
        stim_t t[$];
        apply_reset(); overlap = 1;
        t.push_back(mk(1,1,0,1,0)); t.push_back(mk(1,1,0,2,0)); t.push_back(mk(1,1,0,2,0));
        t.push_back(mk(1,0,0,3,0)); t.push_back(mk(1,1,1,1,1));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL prefix match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL prefix progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL prefix match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    task automatic test_overlap();
        for (int mode = 1; mode >= 0; mode--) begin
            stim_t t[$];
            apply_reset(); overlap = mode[0];
            t.push_back(mk(1,1,0,1,0)); t.push_back(mk(1,1,0,2,0));
            t.push_back(mk(1,0,0,3,0)); t.push_back(mk(1,1,1,(mode != 0) ? 1 : 0,1));
            if (mode != 0) begin
                t.push_back(mk(1,1,0,2,1)); t.push_back(mk(1,0,0,3,1)); t.push_back(mk(1,1,1,1,2));
            end else begin
                t.push_back(mk(1,1,0,1,1)); t.push_back(mk(1,0,0,0,1)); t.push_back(mk(1,1,0,1,1));
            end
            for (int i = 0; i < t.size(); i++) begin
                din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
                sb.push_back(t[i]);
                @(posedge clk); #1;
                e = sb.pop_front();
                n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL overlap%0d match step %0d: got %0b expected %0b", mode, i, match, e.m); end
                n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL overlap%0d progress step %0d: got %0d expected %0d", mode, i, progress, e.p); end
                n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL overlap%0d match_cnt step %0d: got %0d expected %0d", mode, i, match_cnt, e.c); end
            end
        end
    endtask

    task automatic test_gaps();
        stim_t t[$];
        int bits[4] = '{1, 1, 0, 1};
        int prog[4] = '{1, 2, 3, 1};
        apply_reset(); overlap = 1;
        for (int b = 0; b < 4; b++) begin
            t.push_back(mk(1, bits[b], (b == 3) ? 1 : 0, prog[b], (b == 3) ? 1 : 0));
            for (int g = 0; g < 3; g++) t.push_back(mk(0, 0, 0, prog[b], (b == 3) ? 1 : 0));
        end
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL gaps match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL gaps progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL gaps match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    task automatic test_async_reset();
        stim_t t[$];
        apply_reset(); overlap = 1;
        din_valid = 1;
        din = 1; @(posedge clk); #1;
        din = 1; @(posedge clk); #1;
        din = 0; @(posedge clk); #1;
        din_valid = 0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL async_reset match: got %0b expected 0", match); end
        n_checks++; if (progress !== 2'd0) begin n_fail++; $display("FAIL async_reset progress: got %0d expected 0", progress); end
        n_checks++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset match_cnt: got %0d expected 0", match_cnt); end
        n_checks++; if (pattern !== 4'b1101) begin n_fail++; $display("FAIL async_reset pattern: got %b expected 1101", pattern); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        t.push_back(mk(1,1,0,1,0));
        t.push_back(mk(1,1,0,2,0)); t.push_back(mk(1,1,0,2,0));
        t.push_back(mk(1,0,0,3,0)); t.push_back(mk(1,1,1,1,1));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL after_reset match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL after_reset progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL after_reset match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    task automatic test_pat_load();
        stim_t t[$];
        apply_reset(); overlap = 1; pat_in = 4'b0110;
        t.push_back(mk(1,1,0,1,0));
        t.push_back(mk(1,1,0,0,0,1));
        t.push_back(mk(1,0,0,1,0)); t.push_back(mk(1,1,0,2,0));
        t.push_back(mk(1,1,0,3,0)); t.push_back(mk(1,0,1,1,1));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL pat_load match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL pat_load progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL pat_load match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
        n_checks++; if (pattern !== 4'b0110) begin n_fail++; $display("FAIL pat_load pattern: got %b expected 0110", pattern); end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        apply_reset(); overlap = 1; pat_in = 4'b1111;
        t.push_back(mk(0,0,0,0,0,1));
        t.push_back(mk(1,1,0,1,0)); t.push_back(mk(1,1,0,2,0)); t.push_back(mk(1,1,0,3,0));
        t.push_back(mk(1,1,1,3,1)); t.push_back(mk(1,1,1,3,2)); t.push_back(mk(0,0,0,3,2));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL back_to_back match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL back_to_back progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL back_to_back match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    task automatic test_saturation();
        stim_t t[$];
        logic [1:0] c2;
        apply_reset(); overlap = 0;
        for (int r = 1; r <= 5; r++) begin
            t.push_back(mk(1,1,0,1,r-1)); t.push_back(mk(1,1,0,2,r-1));
            t.push_back(mk(1,0,0,3,r-1)); t.push_back(mk(1,1,1,0,r));
        end
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            c2 = (e.c > 8'd3) ? 2'd3 : e.c[1:0];
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL saturate match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL saturate match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
            n_checks++; if (match_cnt2 !== c2) begin n_fail++; $display("FAIL saturate match_cnt_w2 step %0d: got %0d expected %0d", i, match_cnt2, c2); end
        end
    endtask

    task automatic test_cnt_clr();
        stim_t t[$];
        apply_reset(); overlap = 1;
        t.push_back(mk(1,1,0,1,0)); t.push_back(mk(1,1,0,2,0));
        t.push_back(mk(1,0,0,3,0)); t.push_back(mk(1,1,1,1,1));
        t.push_back(mk(1,1,0,2,1)); t.push_back(mk(1,0,0,3,1)); t.push_back(mk(1,1,1,1,2));
        t.push_back(mk(1,1,0,2,2)); t.push_back(mk(1,0,0,3,2)); t.push_back(mk(1,1,1,1,0,0,1));
        t.push_back(mk(0,0,0,1,0));
        for (int i = 0; i < t.size(); i++) begin
            din_valid = t[i].v; din = t[i].d; pat_load = t[i].l; cnt_clr = t[i].k;
            sb.push_back(t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (match !== e.m) begin n_fail++; $display("FAIL cnt_clr match step %0d: got %0b expected %0b", i, match, e.m); end
            n_checks++; if (progress !== e.p) begin n_fail++; $display("FAIL cnt_clr progress step %0d: got %0d expected %0d", i, progress, e.p); end
            n_checks++; if (match_cnt !== e.c) begin n_fail++; $display("FAIL cnt_clr match_cnt step %0d: got %0d expected %0d", i, match_cnt, e.c); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat_prefix();
        test_overlap();
        test_gaps();
        test_async_reset();
        test_pat_load();
        test_back_to_back();
        test_saturation();
        test_cnt_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
